mips_cpu_bus_mem_ctrl: RTL

Parametrised Avalon memory-mapped bus master that serves NPORTS internal requesters (port 0 = instruction fetch, port 1 = load/store unit, further ports for future DMA/debug) over the single CPU Avalon bus. It arbitrates between requesters and issues one transaction at a time, honouring `waitrequest`. It performs MIPS little-endian byte-lane alignment: byteenable generation, writedata lane placement, and readdata extraction with sign/zero extension. It returns a one-cycle acknowledge to the granted port.

---
 rtl/mips_cpu_bus_pkg.sv | 12 +
 rtl/mips_cpu_bus_lane_align.sv | 26 ++
 rtl/mips_cpu_bus_mem_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mips_cpu_bus_pkg.sv
// mips_cpu_bus_pkg: shared types, byte-lane constants and alignment helper for the CPU bus controller
package mips_cpu_bus_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} mem_size_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RDATA, RESP} mem_ctrl_state_t;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  // an unused size encoding is treated as a word everywhere
  function automatic logic misaligned(input logic [1:0] a, input mem_size_t sz);
    return sz == SZ_BYTE ? 1'b0 : sz == SZ_HALF ? a[0] : a != 2'b00;
  endfunction
endpackage

// File: rtl/mips_cpu_bus_lane_align.sv
// mips_cpu_bus_lane_align: little-endian byteenable, store lane placement and load extraction/extension
module mips_cpu_bus_lane_align
  import mips_cpu_bus_pkg::*;
(
  input  logic [1:0]  a,
  input  mem_size_t   sz,
  input  logic        sext,
  input  logic [31:0] wdata_in,
  input  logic [31:0] readdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] load_data
);
  logic [31:0] shifted;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  always_comb begin
    shifted   = readdata >> {a, 3'b000};
    rbyte     = shifted[7:0];
    rhalf     = a[1] ? readdata[31:16] : readdata[15:0];
    be        = sz == SZ_BYTE ? 4'b0001 << a : sz == SZ_HALF ? (a[1] ? BE_HI_HALF : BE_LO_HALF) : BE_WORD;
    wdata_out = sz == SZ_BYTE ? {4{wdata_in[7:0]}} : sz == SZ_HALF ? {2{wdata_in[15:0]}} : wdata_in;
    load_data = sz == SZ_BYTE ? {{24{sext & rbyte[7]}}, rbyte}
              : sz == SZ_HALF ? {{16{sext & rhalf[15]}}, rhalf} : readdata;
  end
endmodule

// File: rtl/mips_cpu_bus_mem_ctrl.sv
// mips_cpu_bus_mem_ctrl: multi-port Avalon-MM master with lane alignment; one transaction at a time.
// Define MIPS_CPU_BUS_MEM_CTRL_RR_EN for round-robin arbitration (default: fixed priority, port 0 first).
module mips_cpu_bus_mem_ctrl
  import mips_cpu_bus_pkg::*;
#(
  parameter int NPORTS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPORTS-1:0]      req,
  input  logic [NPORTS-1:0]      we,
  input  logic [NPORTS-1:0][31:0] addr,
  input  logic [NPORTS-1:0][31:0] wdata,
  input  logic [NPORTS-1:0][1:0] size,
  input  logic [NPORTS-1:0]      sext,
  output logic [NPORTS-1:0]      ack,
  output logic [31:0]            rdata,
  output logic                   err,
  output logic                   busy,
  output logic [31:0]            address,
  output logic                   write,
  output logic                   read,
  input  logic                   waitrequest,
  output logic [31:0]            writedata,
  output logic [3:0]             byteenable,
  input  logic [31:0]            readdata
);
  localparam int PW = NPORTS > 1 ? $clog2(NPORTS) : 1;
  mem_ctrl_state_t state_q, state_d;
  mem_size_t       size_q, size_d;
  logic [PW-1:0]   grant_q, grant_d, sel;
  logic            we_q, we_d, sext_q, sext_d, err_q, err_d, granting;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]      be;
  logic [31:0]     wd_lane, load_data;
  assign granting = state_q == IDLE && |req;
`ifdef MIPS_CPU_BUS_MEM_CTRL_RR_EN
  logic [PW-1:0] last_q, last_d;
  // walk from farthest to nearest so the port right after the last grant wins
  always_comb begin
    sel = last_q;
    for (int i = NPORTS; i >= 1; i--)
      if (req[(int'(last_q) + i) % NPORTS]) sel = PW'((int'(last_q) + i) % NPORTS);
    last_d = granting ? sel : last_q;
  end
  always_ff @(posedge clk) last_q <= reset ? PW'(NPORTS - 1) : last_d;
`else
  always_comb begin
    sel = '0;
    for (int i = NPORTS - 1; i >= 0; i--)
      if (req[i]) sel = PW'(i);
  end
`endif
  mips_cpu_bus_lane_align u_align (
    .a        (addr_q[1:0]),
    .sz       (size_q),
    .sext     (sext_q),
    .wdata_in (wdata_q),
    .readdata (readdata),
    .be       (be),
    .wdata_out(wd_lane),
    .load_data(load_data)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sext_d  = sext_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (granting) begin
        grant_d = sel;
        we_d    = we[sel];
        addr_d  = addr[sel];
        wdata_d = wdata[sel];
        size_d  = mem_size_t'(size[sel]);
        sext_d  = sext[sel];
        err_d   = misaligned(addr[sel][1:0], mem_size_t'(size[sel]));
        rdata_d = '0;
        state_d = err_d ? RESP : ISSUE;
      end
      ISSUE: state_d = waitrequest ? ISSUE : we_q ? RESP : RDATA;
      RDATA: begin
        rdata_d = load_data;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign read       = state_q == ISSUE && !we_q;
  assign write      = state_q == ISSUE && we_q;
  assign address    = (read || write) ? {addr_q[31:2], 2'b00} : '0;
  assign byteenable = (read || write) ? be : '0;
  assign writedata  = write ? wd_lane : '0;
  assign ack        = state_q == RESP ? NPORTS'(1) << grant_q : '0;
  assign err        = state_q == RESP && err_q;
  assign rdata      = rdata_q;
endmodule
